// File: rtl/ram_mmio.sv
// rtl/ram_mmio.sv - unified program/data RAM with MMIO registers and async loader port
// Combinational fetch/data reads; loader writes enter through a pg_wr synchroniser and edge detector.
module ram_mmio #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int DEPTH        = 256,
  parameter int NUM_PORTS    = 2,
  parameter int PORT_IN_ADDR = 15,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           pc,
  output logic [DATA_W-1:0]           ir,
  input  logic [ADDR_W-1:0]           addr,
  input  logic                        rw,
  input  logic [DATA_W-1:0]           mem_in,
  output logic [DATA_W-1:0]           mem_out,
  input  logic                        pgm,
  input  logic                        pg_wr,
  input  logic                        pg_auto,
  input  logic [ADDR_W-1:0]           pg_addr,
  input  logic [DATA_W-1:0]           pg_data,
  output logic                        pg_ack,
  output logic [15:0]                 pg_count,
  output logic                        cpu_hold,
  output logic [DATA_W-1:0]           sys_ctrl,
  output logic [NUM_PORTS*DATA_W-1:0] port_out,
  input  logic [DATA_W-1:0]           port_in
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PIN_L    = ADDR_W'(PORT_IN_ADDR);
  localparam logic [IDX_W-1:0]  PTR_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE, LOAD} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0]      regs [0:NUM_PORTS];
  logic [DATA_W-1:0]      mem  [0:DEPTH-1];
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   pg_edge;
  logic [IDX_W-1:0]       ptr;
  logic                   wr_en, ld_start, ld_commit;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;

  // Register window takes precedence over the array; port_in address wins over both.
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    if (a == PIN_L) begin
      r = port_in;
    end else if ({1'b0, a} < DEPTH_L) begin
      r = mem[a[IDX_W-1:0]];
      for (int i = 0; i <= NUM_PORTS; i++)
        if (a == ADDR_W'(i)) r = regs[i];
    end
    return r;
  endfunction

  assign ir       = rd(pc);
  assign mem_out  = rd(addr);
  assign sys_ctrl = regs[0];
  assign cpu_hold = (state == LOAD);
  assign pg_edge  = sync[SYNC_STAGES-1] & ~hist;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign port_out[g*DATA_W +: DATA_W] = regs[g+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pg_wr};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    wr_addr   = addr;
    wr_data   = mem_in;
    ld_start  = 1'b0;
    ld_commit = 1'b0;
    case (state)
      IDLE: begin
        if (pgm) begin
          state_nx = LOAD;
          ld_start = 1'b1;
        end else if (rw) begin
          wr_en = 1'b1;
        end
      end
      LOAD: begin
        // Leaving LOAD takes priority over a strobe detected in the same cycle.
        if (!pgm) begin
          state_nx = IDLE;
        end else if (pg_edge) begin
          ld_commit = 1'b1;
          wr_en     = 1'b1;
          wr_addr   = pg_auto ? ADDR_W'(ptr) : pg_addr;
          wr_data   = pg_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      pg_count <= '0;
      pg_ack   <= 1'b0;
      for (int i = 0; i <= NUM_PORTS; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      if (ld_start) begin
        ptr      <= '0;
        pg_count <= '0;
      end
      if (ld_commit) begin
        pg_ack <= ~pg_ack;
        if (pg_count != 16'hFFFF) pg_count <= pg_count + 16'd1;
        if (pg_auto) ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end
      if (wr_en && wr_addr != PIN_L)
        for (int i = 0; i <= NUM_PORTS; i++)
          if (wr_addr == ADDR_W'(i)) regs[i] <= wr_data;
    end
  end

  // Array is deliberately not reset so program images survive a core reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && wr_addr != PIN_L && {1'b0, wr_addr} < DEPTH_L)
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_ram_mmio.sv
// tb/tb_ram_mmio.sv - randomized self-checking bench for ram_mmio
// Reference model is a plain word map plus loader pointer/count/ack bookkeeping.
module tb_ram_mmio;

  logic        clk = 1'b0;
  logic        rst, rw, pgm, pg_wr, pg_auto, pg_ack, cpu_hold;
  logic [15:0] pc, addr, mem_in, pg_addr, pg_data, port_in;
  logic [15:0] ir, mem_out, pg_count, sys_ctrl;
  logic [31:0] port_out;

  ram_mmio dut (
    .clk(clk), .rst(rst), .pc(pc), .ir(ir), .addr(addr), .rw(rw),
    .mem_in(mem_in), .mem_out(mem_out), .pgm(pgm), .pg_wr(pg_wr),
    .pg_auto(pg_auto), .pg_addr(pg_addr), .pg_data(pg_data),
    .pg_ack(pg_ack), .pg_count(pg_count), .cpu_hold(cpu_hold),
    .sys_ctrl(sys_ctrl), .port_out(port_out), .port_in(port_in)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0;
  logic [15:0] m_reg [0:2];
  logic [15:0] m_mem [0:255];
  bit          m_known [0:255];
  int          m_ptr = 0, m_count = 0;
  bit          m_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_rd(input int a, output bit k);
    k = 1'b1;
    if (a == 15) return port_in;
    if (a <= 2) return m_reg[a];
    if (a < 256) begin
      k = m_known[a];
      return m_mem[a];
    end
    return 16'h0;
  endfunction

  function automatic void m_wr(input int a, input logic [15:0] d);
    if (a == 15) return;
    if (a <= 2) m_reg[a] = d;
    else if (a < 256) begin
      m_mem[a]   = d;
      m_known[a] = 1'b1;
    end
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0, 1, 2: return 16'($urandom_range(0, 2));
      3:       return 16'd15;
      4:       return 16'($urandom_range(256, 65535));
      default: return 16'($urandom_range(3, 40));
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag);
    bit k;
    logic [15:0] e;
    #1;
    e = m_rd(int'(addr), k);
    if (k) check({tag, ":mem_out"}, {16'h0, mem_out}, {16'h0, e});
    e = m_rd(int'(pc), k);
    if (k) check({tag, ":ir"}, {16'h0, ir}, {16'h0, e});
    check({tag, ":sys_ctrl"}, {16'h0, sys_ctrl}, {16'h0, m_reg[0]});
    check({tag, ":port_out"}, port_out, {m_reg[2], m_reg[1]});
  endtask

  // abort: 0 = normal, 1 = pgm drops in the detect cycle, 2 = rst in the detect cycle
  task automatic pulse(input logic [15:0] d, input bit autom, input logic [15:0] ea, input int abort);
    int tgt;
    tgt     = autom ? m_ptr : int'(ea);
    pg_data = d;
    pg_auto = autom;
    pg_addr = ea;
    addr    = 16'(tgt);
    pc      = pick();
    rw      = 1'b0;
    #($urandom_range(1, 6));
    pg_wr = 1'b1;
    step();
    step();
    check("pre_commit_count", {16'h0, pg_count}, 32'(m_count));
    check("pre_commit_ack", {31'h0, pg_ack}, {31'h0, m_ack});
    if (abort == 1) pgm = 1'b0;
    if (abort == 2) begin
      rst = 1'b1;
      pgm = 1'b0;
    end
    step();
    rst = 1'b0;
    if (abort == 0) begin
      m_wr(tgt, d);
      m_ack = ~m_ack;
      if (m_count < 16'hFFFF) m_count++;
      if (autom) m_ptr = (m_ptr + 1) % 256;
    end else if (abort == 2) begin
      m_count = 0;
      m_ack   = 1'b0;
      m_ptr   = 0;
      for (int i = 0; i < 3; i++) m_reg[i] = 16'h0;
    end
    check("commit_count", {16'h0, pg_count}, 32'(m_count));
    check("commit_ack", {31'h0, pg_ack}, {31'h0, m_ack});
    check("commit_hold", {31'h0, cpu_hold}, (abort == 0) ? 32'd1 : 32'd0);
    chk_all("commit");
    repeat ($urandom_range(0, 2)) begin
      if (abort == 0) begin
        rw     = 1'($urandom_range(0, 1));
        mem_in = 16'($urandom);
      end
      step();
    end
    pg_wr = 1'b0;
    repeat ($urandom_range(2, 3)) step();
    rw = 1'b0;
    chk_all("post_pulse");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rw = 1'b0; pgm = 1'b0; pg_wr = 1'b0; pg_auto = 1'b0;
    pc = 16'h0; addr = 16'h0; mem_in = 16'h0; pg_addr = 16'h0; pg_data = 16'h0;
    port_in = 16'h0;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    for (int i = 0; i < 3; i++) m_reg[i] = 16'h0;
    step();
    step();
    rst = 1'b0;
    check("rst_sys_ctrl", {16'h0, sys_ctrl}, 32'h0);
    check("rst_port_out", port_out, 32'h0);
    check("rst_pg_count", {16'h0, pg_count}, 32'h0);
    check("rst_pg_ack", {31'h0, pg_ack}, 32'h0);
    check("rst_cpu_hold", {31'h0, cpu_hold}, 32'h0);

    // Reset keeps the array but clears registers; a write in the rst cycle is dropped.
    rw = 1'b1;
    addr = 16'd0;  mem_in = 16'd5;      step(); m_wr(0, 16'd5);
    addr = 16'd20; mem_in = 16'h1234;   step(); m_wr(20, 16'h1234);
    addr = 16'd21; mem_in = 16'h7777;   step(); m_wr(21, 16'h7777);
    rw = 1'b0;
    chk_all("pre_rst");
    rst = 1'b1; rw = 1'b1; addr = 16'd21; mem_in = 16'h0;
    step();
    rst = 1'b0; rw = 1'b0;
    for (int i = 0; i < 3; i++) m_reg[i] = 16'h0;
    check("rst2_sys_ctrl", {16'h0, sys_ctrl}, 32'h0);
    check("rst2_pg_count", {16'h0, pg_count}, 32'h0);
    addr = 16'd20; #1;
    check("rst_keeps_word20", {16'h0, mem_out}, 32'h1234);
    addr = 16'd21; #1;
    check("rst_cycle_write_dropped", {16'h0, mem_out}, 32'h7777);

    // Directed MMIO writes.
    rw = 1'b1;
    addr = 16'd1;  mem_in = 16'hA5A5; step(); m_wr(1, 16'hA5A5);
    addr = 16'd2;  mem_in = 16'h5A5A; step(); m_wr(2, 16'h5A5A);
    addr = 16'd15; mem_in = 16'h1234; step();
    rw = 1'b0; port_in = 16'hBEEF;
    #1;
    check("port_out_a5", port_out, 32'h5A5A_A5A5);
    check("port_in_read", {16'h0, mem_out}, 32'h0000_BEEF);
    addr = 16'd300; #1;
    check("unmapped_read", {16'h0, mem_out}, 32'h0);

    // Random CPU traffic.
    repeat (60) begin
      addr    = pick();
      pc      = pick();
      rw      = 1'($urandom_range(0, 1));
      mem_in  = 16'($urandom);
      port_in = 16'($urandom);
      chk_all("cpu_pre");
      step();
      if (rw) m_wr(int'(addr), mem_in);
      rw = 1'b0;
      chk_all("cpu_post");
    end

    // Enter LOAD with a simultaneous CPU write that must be ignored.
    pgm = 1'b1; rw = 1'b1; addr = 16'd1; mem_in = 16'hFFFF;
    step();
    rw = 1'b0; m_ptr = 0; m_count = 0;
    check("load_hold", {31'h0, cpu_hold}, 32'd1);
    check("load_entry_count", {16'h0, pg_count}, 32'h0);
    chk_all("load_entry");

    for (int i = 1; i <= 4; i++) pulse(16'(i), 1'b1, 16'h0, 0);
    check("auto4_count", {16'h0, pg_count}, 32'd4);
    pulse(16'hC0DE, 1'b0, 16'd300, 0);
    addr = 16'd300; #1;
    check("explicit_unmapped", {16'h0, mem_out}, 32'h0);
    pulse(16'h2222, 1'b0, 16'd2, 0);
    pulse(16'h5050, 1'b0, 16'd50, 0);
    check("explicit_keeps_ptr", 32'(m_ptr), 32'd4);
    repeat (254) pulse(16'($urandom), 1'b1, 16'h0, 0);
    check("wrap_ptr_model", 32'(m_ptr), 32'd2);
    for (int a = 0; a < 2; a++) begin
      addr = 16'(a);
      chk_all("wrap_words");
    end

    // Strobe detected as pgm drops: discarded.
    pulse(16'hDEAD, 1'b0, 16'd60, 1);

    // Strobe detected in the rst cycle: discarded, state reset.
    pgm = 1'b1;
    step();
    m_ptr = 0; m_count = 0;
    pulse(16'h1111, 1'b0, 16'd100, 0);
    pulse(16'h9999, 1'b0, 16'd100, 2);
    addr = 16'd100; #1;
    check("rst_abort_word", {16'h0, mem_out}, 32'h1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
